dds_chirp_core: RTL and testbench
=================================

# dds_chirp_core

Receiving end of the REQ/ACK parameter link from the pulse sequencer, plus the linear-FM phase accumulator it feeds. It sits entirely in the DDS clock domain. It synchronises the sequencer's REQ and DDS_start and captures the chirp parameters with a 4-phase handshake. While the synchronised start level is high, it generates a swept phase word for the sine LUT downstream.

## Interface
- PHASE_W, 48, width of frequency, delta-frequency and phase words
- SYNC_STAGES, 2, flip-flops in each REQ / DDS_start synchroniser (≥2)

- CLK  in  1  DDS clock; the only clock in the block
- RESET_N  in  1  synchronous, active-low reset
- REQ  in  1  sequencer data-valid request, asynchronous to CLK
- ACK  out  1  capture acknowledge back to the sequencer
- DDS_freq  in  PHASE_W  start frequency word; stable while REQ=1
- DDS_delta_freq  in  PHASE_W  frequency step per sweep tick; stable while REQ=1
- DDS_delta_rate  in  32  clocks per sweep tick; 0 = no sweep; stable while REQ=1
- DDS_start  in  1  run level from the sequencer, asynchronous
- PHASE  out  PHASE_W  phase accumulator output
- FREQ_CUR  out  PHASE_W  current instantaneous frequency word
- PHASE_VALID  out  1  high while the engine is running
- CFG_LOADED  out  1  one-cycle pulse when new parameters are captured

## Operation
- Synchronisers: REQ and DDS_start each pass through SYNC_STAGES flops, giving req_s and start_s. Start edge detection uses a further register start_d.
- Handshake FSM, states H_IDLE and H_ACK:
  - H_IDLE: when req_s=1, latch DDS_freq, DDS_delta_freq and DDS_delta_rate into the shadow registers, set ACK←1, pulse CFG_LOADED, and go to H_ACK.
  - H_ACK: hold ACK=1 and ignore the inputs. When req_s=0, set ACK←0 and go to H_IDLE.
  - Exactly one capture occurs per REQ high period.
- Chirp FSM, states C_STOP and C_RUN:
  - C_STOP: PHASE_VALID=0 and PHASE=0; FREQ_CUR holds its value.
  - On start_s=1 with start_d=0: FREQ_CUR←shadow_freq, PHASE←0, rate_cnt←0, go to C_RUN.
  - C_RUN: PHASE←PHASE+FREQ_CUR, modulo 2^PHASE_W.
  - If shadow_rate≠0: rate_cnt increments. When rate_cnt=shadow_rate−1, set FREQ_CUR←FREQ_CUR+shadow_dfreq (modulo 2^PHASE_W) and rate_cnt←0.
  - If shadow_rate=0: FREQ_CUR stays constant.
  - When start_s=0, go to C_STOP.
- Coherent bursts: the sequencer keeps DDS_start high across pulses. The engine keeps running, and the sweep does not restart.
- A capture during C_RUN updates only the shadow registers. It does not affect FREQ_CUR or the sweep until the next start rising edge.
- Capture and start edge in the same cycle: the start loads the pre-capture shadow values. The new values apply at the next start.
- All arithmetic is unsigned and wraps. There is no saturation, and no overflow flag.

## Timing
- Reset values: ACK=0, PHASE=0, FREQ_CUR=0, PHASE_VALID=0, CFG_LOADED=0. Shadow registers, rate_cnt and all synchroniser flops are also 0. Both FSMs reset to their idle/stop states.
- REQ↑ to ACK↑ is SYNC_STAGES+1 CLK edges, 3 by default. CFG_LOADED pulses in the same cycle that ACK rises.
- REQ↓ to ACK↓ is SYNC_STAGES+1 edges.
- DDS_start↑ to PHASE_VALID↑ is SYNC_STAGES+1 edges. The first valid cycle has PHASE=0 and FREQ_CUR=shadow_freq.
- DDS_start↓ to PHASE_VALID↓ is SYNC_STAGES+1 edges. PHASE clears in the same cycle.
- Start pulses shorter than the synchroniser can resolve are not guaranteed to be seen. The sequencer holds DDS_start for at least 2 of its clocks.
- Reset mid-operation: all state returns to its reset values on the next edge.
  - If REQ is still high after reset, it is re-captured, and ACK rises SYNC_STAGES+1 edges after RESET_N rises.
  - If DDS_start is still high after reset, start_d=0 reads it as a new edge, so the engine restarts.

## Test plan
- Handshake: DDS_freq=0x1000, DDS_delta_freq=0x10, DDS_delta_rate=3; REQ↑ at edge 0 → ACK=1 and CFG_LOADED pulse at edge 3; REQ↓ at edge 10 → ACK=0 at edge 13; no second CFG_LOADED.
- Constant tone: freq=0x1000, rate=0; DDS_start↑ → PHASE 0, 0x1000, 0x2000, 0x3000… and FREQ_CUR stays 0x1000.
- Sweep: freq=0x100, dfreq=0x10, rate=3 → FREQ_CUR 0x100×3, 0x110×3, 0x120…; PHASE 0, 0x100, 0x200, 0x300, 0x410, 0x520, 0x630.
- Wrap: freq=0xFFFF_FFFF_FFFF, rate=0 → PHASE 0, 0xFFFF_FFFF_FFFF, 0xFFFF_FFFF_FFFE.
- Capture while running: run with freq=0x1000, then handshake freq=0x2000 → FREQ_CUR stays 0x1000; DDS_start↓ then ↑ → FREQ_CUR=0x2000 on the first valid cycle.
- Reset mid-run, REQ and DDS_start still high: RESET_N low for 1 edge → all outputs 0; ACK=1 at edge 3 after release; PHASE_VALID=1 with PHASE=0 at edge 3.

Source files
------------

// File: rtl/dds_chirp_core.sv
`timescale 1ns / 1ps
// dds_chirp_core
//
// Purpose:
//   This block receives chirp parameters from the pulse sequencer over a
//   4-phase REQ/ACK link. It then runs a linear-FM phase accumulator for the
//   sine LUT downstream. Everything runs on CLK.
//   REQ and DDS_start come from the sequencer's clock domain, so each one is
//   synchronised before use.
//
// Ports:
//   CLK             DDS clock; the only clock in the block
//   RESET_N         synchronous, active-low reset
//   REQ             sequencer data-valid request (asynchronous)
//   ACK             capture acknowledge back to the sequencer
//   DDS_freq        start frequency word (stable while REQ=1)
//   DDS_delta_freq  frequency step per sweep tick (stable while REQ=1)
//   DDS_delta_rate  clocks per sweep tick, 0 = no sweep (stable while REQ=1)
//   DDS_start       run level from the sequencer (asynchronous)
//   PHASE           phase accumulator output
//   FREQ_CUR        current instantaneous frequency word
//   PHASE_VALID     high while the engine is running
//   CFG_LOADED      one-cycle pulse when new parameters are captured
module dds_chirp_core #(
  parameter int PHASE_W     = 48,
  parameter int SYNC_STAGES = 2
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               REQ,
  output logic               ACK,
  input  logic [PHASE_W-1:0] DDS_freq,
  input  logic [PHASE_W-1:0] DDS_delta_freq,
  input  logic [31:0]        DDS_delta_rate,
  input  logic               DDS_start,
  output logic [PHASE_W-1:0] PHASE,
  output logic [PHASE_W-1:0] FREQ_CUR,
  output logic               PHASE_VALID,
  output logic               CFG_LOADED
);

  localparam logic [0:0] H_IDLE = 1'b0;
  localparam logic [0:0] H_ACK  = 1'b1;
  localparam logic [0:0] C_STOP = 1'b0;
  localparam logic [0:0] C_RUN  = 1'b1;

  // ---------------------------------------------------------------------
  // Synchronisers. Bit 0 is the first flop, and the top bit is the resolved level.
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] req_sync_reg;
  logic [SYNC_STAGES-1:0] start_sync_reg;
  logic                   req_s;
  logic                   start_s;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      req_sync_reg   <= '0;
      start_sync_reg <= '0;
    end else begin
      req_sync_reg   <= {req_sync_reg[SYNC_STAGES-2:0], REQ};
      start_sync_reg <= {start_sync_reg[SYNC_STAGES-2:0], DDS_start};
    end
  end

  assign req_s   = req_sync_reg[SYNC_STAGES-1];
  assign start_s = start_sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Handshake FSM and shadow parameter registers
  // ---------------------------------------------------------------------
  logic [0:0]         h_state_reg;
  logic               ack_reg;
  logic               cfg_loaded_reg;
  logic [PHASE_W-1:0] shadow_freq_reg;
  logic [PHASE_W-1:0] shadow_dfreq_reg;
  logic [31:0]        shadow_rate_reg;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      h_state_reg      <= H_IDLE;
      ack_reg          <= 1'b0;
      cfg_loaded_reg   <= 1'b0;
      shadow_freq_reg  <= '0;
      shadow_dfreq_reg <= '0;
      shadow_rate_reg  <= '0;
    end else begin
      cfg_loaded_reg <= 1'b0;
      case (h_state_reg)
        H_IDLE: begin
          if (req_s) begin
            shadow_freq_reg  <= DDS_freq;
            shadow_dfreq_reg <= DDS_delta_freq;
            shadow_rate_reg  <= DDS_delta_rate;
            ack_reg          <= 1'b1;
            cfg_loaded_reg   <= 1'b1;
            h_state_reg      <= H_ACK;
          end
        end
        H_ACK: begin
          // Inputs are ignored until REQ drops. This gives one capture per REQ pulse.
          if (!req_s) begin
            ack_reg     <= 1'b0;
            h_state_reg <= H_IDLE;
          end
        end
        default: begin
          ack_reg     <= 1'b0;
          h_state_reg <= H_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Chirp engine
  //   The step and rate are copied at the start edge. A capture that lands
  //   mid-run therefore cannot disturb the sweep in progress. The shadow
  //   registers are read with their pre-edge values. So a capture in the same
  //   cycle as a start edge takes effect only from the following start.
  // ---------------------------------------------------------------------
  logic [0:0]         c_state_reg;
  logic               start_d_reg;
  logic [PHASE_W-1:0] phase_reg;
  logic [PHASE_W-1:0] freq_reg;
  logic [PHASE_W-1:0] run_dfreq_reg;
  logic [31:0]        run_rate_reg;
  logic [31:0]        rate_cnt_reg;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      c_state_reg   <= C_STOP;
      start_d_reg   <= 1'b0;
      phase_reg     <= '0;
      freq_reg      <= '0;
      run_dfreq_reg <= '0;
      run_rate_reg  <= '0;
      rate_cnt_reg  <= '0;
    end else begin
      start_d_reg <= start_s;
      case (c_state_reg)
        C_STOP: begin
          phase_reg <= '0;
          if (start_s && !start_d_reg) begin
            freq_reg      <= shadow_freq_reg;
            run_dfreq_reg <= shadow_dfreq_reg;
            run_rate_reg  <= shadow_rate_reg;
            rate_cnt_reg  <= '0;
            c_state_reg   <= C_RUN;
          end
        end
        C_RUN: begin
          if (!start_s) begin
            phase_reg   <= '0;
            c_state_reg <= C_STOP;
          end else begin
            phase_reg <= phase_reg + freq_reg;
            if (run_rate_reg != 32'd0) begin
              if (rate_cnt_reg == run_rate_reg - 32'd1) begin
                freq_reg     <= freq_reg + run_dfreq_reg;
                rate_cnt_reg <= '0;
              end else begin
                rate_cnt_reg <= rate_cnt_reg + 32'd1;
              end
            end
          end
        end
        default: begin
          phase_reg   <= '0;
          c_state_reg <= C_STOP;
        end
      endcase
    end
  end

  assign ACK         = ack_reg;
  assign CFG_LOADED  = cfg_loaded_reg;
  assign PHASE       = phase_reg;
  assign FREQ_CUR    = freq_reg;
  assign PHASE_VALID = (c_state_reg == C_RUN);

endmodule

// File: tb/tb_dds_chirp_core.sv
`timescale 1ns / 1ps
// Testbench for dds_chirp_core.
// Stimulus tasks push the expected PHASE/FREQ_CUR stream of every burst, and
// the expected CFG_LOADED pulses, into queues. A negedge monitor pops these
// queues and compares whenever the DUT presents valid data.
module tb_dds_chirp_core;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        REQ = 1'b0;
  logic        ACK;
  logic [47:0] DDS_freq = '0;
  logic [47:0] DDS_delta_freq = '0;
  logic [31:0] DDS_delta_rate = '0;
  logic        DDS_start = 1'b0;
  logic [47:0] PHASE;
  logic [47:0] FREQ_CUR;
  logic        PHASE_VALID;
  logic        CFG_LOADED;

  dds_chirp_core #(.PHASE_W(48), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .REQ(REQ), .ACK(ACK),
    .DDS_freq(DDS_freq), .DDS_delta_freq(DDS_delta_freq),
    .DDS_delta_rate(DDS_delta_rate), .DDS_start(DDS_start),
    .PHASE(PHASE), .FREQ_CUR(FREQ_CUR), .PHASE_VALID(PHASE_VALID),
    .CFG_LOADED(CFG_LOADED)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct packed {
    logic [47:0] ph;
    logic [47:0] fr;
  } exp_t;

  exp_t exp_q[$];
  int   cfg_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b1;

  // Reference copy of the parameters the DUT should hold after each capture
  logic [47:0] m_f = '0, m_df = '0;
  logic [31:0] m_r = '0;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [47:0] rnd48();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[47:0];
  endfunction

  // Expected output of a burst of h valid cycles. The frequency at cycle k is
  // f0 + floor(k/rate)*df. The phase is the running sum of earlier frequencies.
  task automatic push_exp(input int h);
    logic [47:0] ph, fr;
    ph = '0;
    for (int k = 0; k < h; k++) begin
      fr = m_f + ((m_r == 32'd0) ? 48'd0 : 48'(32'(k) / m_r) * m_df);
      exp_q.push_back('{ph: ph, fr: fr});
      ph = ph + fr;
    end
  endtask

  // Wait for ACK (sel=0) or PHASE_VALID (sel=1) to reach lvl. The expected
  // latency is 3 edges.
  task automatic wait_lvl(input int sel, input logic lvl, input string nm);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (((sel == 0) ? ACK : PHASE_VALID) !== lvl && n < 20);
    chk(nm, 48'(n), 48'd3);
  endtask

  task automatic hs_raise(input logic [47:0] f, input logic [47:0] df, input logic [31:0] r);
    DDS_freq       = f;
    DDS_delta_freq = df;
    DDS_delta_rate = r;
    REQ            = 1'b1;
    cfg_q.push_back(1);
    m_f  = f;
    m_df = df;
    m_r  = r;
  endtask

  task automatic hs_drop();
    REQ = 1'b0;
    wait_lvl(0, 1'b0, "ack_fall_lat");
  endtask

  task automatic handshake(input logic [47:0] f, input logic [47:0] df, input logic [31:0] r);
    hs_raise(f, df, r);
    wait_lvl(0, 1'b1, "ack_rise_lat");
    repeat (4) tick();
    chk("ack_hold", 48'(ACK), 48'd1);
    hs_drop();
    repeat (2) tick();
  endtask

  // mode 0: plain burst. mode 1: capture (nf/ndf/nr) while running.
  // mode 2: REQ rises together with DDS_start.
  task automatic run(input int h, input int mode, input logic [47:0] nf,
                     input logic [47:0] ndf, input logic [31:0] nr);
    int t0;
    push_exp(h);
    if (mode == 2) hs_raise(nf, ndf, nr);
    DDS_start = 1'b1;
    t0 = cyc;
    wait_lvl(1, 1'b1, "start_lat");
    if (mode == 2) begin
      chk("ack_with_start", 48'(ACK), 48'd1);
      hs_drop();
    end
    if (mode == 1) begin
      hs_raise(nf, ndf, nr);
      wait_lvl(0, 1'b1, "ack_rise_lat_run");
      hs_drop();
    end
    while (cyc < t0 + h) tick();
    DDS_start = 1'b0;
    wait_lvl(1, 1'b0, "stop_lat");
    repeat (3) tick();
    chk("burst_drain", 48'(exp_q.size()), 48'd0);
  endtask

  // Monitor: compares each valid cycle against the next expected entry.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (PHASE_VALID) begin
        if (exp_q.size() == 0) begin
          chk("valid_unexpected", 48'(PHASE_VALID), 48'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("phase", PHASE, e.ph);
          chk("freq_cur", FREQ_CUR, e.fr);
        end
      end else begin
        chk("phase_idle", PHASE, 48'd0);
      end
      if (CFG_LOADED) begin
        if (cfg_q.size() == 0) begin
          chk("cfg_unexpected", 48'(CFG_LOADED), 48'd0);
        end else begin
          void'(cfg_q.pop_front());
          chk("ack_at_cfg", 48'(ACK), 48'd1);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, mode, t0;
    // Reset state
    repeat (2) tick();
    chk("rst_ack", 48'(ACK), 48'd0);
    chk("rst_phase", PHASE, 48'd0);
    chk("rst_freq", FREQ_CUR, 48'd0);
    chk("rst_valid", 48'(PHASE_VALID), 48'd0);
    chk("rst_cfg", 48'(CFG_LOADED), 48'd0);
    RESET_N = 1'b1;
    repeat (2) tick();

    // Handshake only
    handshake(48'h1000, 48'h10, 32'd3);
    repeat (4) tick();
    chk("single_cfg", 48'(cfg_q.size()), 48'd0);

    // Constant tone
    handshake(48'h1000, 48'h0, 32'd0);
    run(20, 0, '0, '0, '0);
    // Sweep
    handshake(48'h100, 48'h10, 32'd3);
    run(20, 0, '0, '0, '0);
    // Wrap
    handshake(48'hFFFF_FFFF_FFFF, 48'h0, 32'd0);
    run(10, 0, '0, '0, '0);
    // Capture while running, then a restart picks up the new word
    handshake(48'h1000, 48'h0, 32'd0);
    run(30, 1, 48'h2000, 48'h0, 32'd0);
    run(10, 0, '0, '0, '0);
    // Capture coincident with the start edge
    run(30, 2, 48'h3000, 48'h5, 32'd2);
    run(10, 0, '0, '0, '0);

    // Randomised bursts
    for (int i = 0; i < 10; i++) begin
      h = $urandom_range(25, 40);
      mode = $urandom_range(0, 2);
      if (mode == 0) handshake(rnd48(), rnd48(), $urandom_range(0, 4));
      run(h, mode, rnd48(), rnd48(), $urandom_range(0, 4));
    end

    // Reset mid-run with REQ and DDS_start still high
    mon_en = 1'b0;
    DDS_freq = rnd48();
    DDS_delta_freq = rnd48();
    DDS_delta_rate = 32'd2;
    REQ = 1'b1;
    DDS_start = 1'b1;
    repeat (12) tick();
    RESET_N = 1'b0;
    tick();
    chk("midrst_ack", 48'(ACK), 48'd0);
    chk("midrst_phase", PHASE, 48'd0);
    chk("midrst_freq", FREQ_CUR, 48'd0);
    chk("midrst_valid", 48'(PHASE_VALID), 48'd0);
    chk("midrst_cfg", 48'(CFG_LOADED), 48'd0);
    exp_q.delete();
    cfg_q.delete();
    // The restart and the re-capture coincide, so the burst runs from the
    // cleared shadow value (zero).
    m_f = '0; m_df = '0; m_r = '0;
    h = 20;
    push_exp(h);
    cfg_q.push_back(1);
    m_f = DDS_freq; m_df = DDS_delta_freq; m_r = DDS_delta_rate;
    RESET_N = 1'b1;
    mon_en = 1'b1;
    t0 = cyc;
    wait_lvl(0, 1'b1, "ack_after_reset");
    chk("valid_after_reset", 48'(PHASE_VALID), 48'd1);
    chk("phase_after_reset", PHASE, 48'd0);
    hs_drop();
    while (cyc < t0 + h) tick();
    DDS_start = 1'b0;
    wait_lvl(1, 1'b0, "stop_lat_reset");
    repeat (3) tick();
    chk("burst_drain_reset", 48'(exp_q.size()), 48'd0);
    // New parameters apply on the next start
    run(12, 0, '0, '0, '0);

    repeat (4) tick();
    chk("cfg_drain", 48'(cfg_q.size()), 48'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
